// File: rtl/lcd_pixel_feeder.sv
`default_nettype none
// lcd_pixel_feeder: requests frame lines from a DDR reader into a 2**FIFO_AW-word
// pixel FIFO and serves RGB565 pixels to the LCD timing generator one cycle after each request.
module lcd_pixel_feeder #(
  parameter int          FIFO_AW     = 11,
  parameter logic [15:0] UFLOW_COLOR = 16'hF800
) (
  input  logic        lcd_clk,
  input  logic        sys_rst_n,
  input  logic        out_vsync,
  input  logic        data_req,
  input  logic [10:0] h_disp,
  input  logic [10:0] v_disp,
  output logic [15:0] pixel_data,
  output logic        frame_start,
  output logic        line_req,
  output logic [10:0] line_num,
  input  logic [15:0] rd_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  output logic        underflow
);

  localparam int               DEPTH   = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_W = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               vs_d, vs_edge;
  logic [10:0]        h_lat, v_lat, line_cnt, recv_cnt;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [15:0]        mem [DEPTH];
  logic               full, empty, push, pop, space_ok, issue;

  assign vs_edge  = out_vsync && !vs_d;
  assign full     = (count == DEPTH_W);
  assign empty    = (count == '0);
  assign space_ok = 32'(DEPTH_W - count) >= 32'(h_lat);
  assign rd_ready = (state == WAIT) && !full && (recv_cnt < h_lat);
  // A vsync edge wins over any transfer or pop landing in the same cycle.
  assign push     = rd_valid && rd_ready && !vs_edge;
  assign pop      = data_req && (state != IDLE) && !vs_edge && !empty;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    if (vs_edge) begin
      state_nxt = REQ;
    end else begin
      case (state)
        REQ: begin
          if (line_cnt == v_lat) begin
            state_nxt = DONE;
          end else if ((line_cnt < v_lat) && space_ok) begin
            issue     = 1'b1;
            state_nxt = WAIT;
          end
        end
        WAIT:    if (recv_cnt >= h_lat) state_nxt = REQ;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_d        <= 1'b0;
      frame_start <= 1'b0;
      line_req    <= 1'b0;
      line_num    <= '0;
      pixel_data  <= '0;
      underflow   <= 1'b0;
      h_lat       <= '0;
      v_lat       <= '0;
      line_cnt    <= '0;
      recv_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      vs_d        <= out_vsync;
      frame_start <= vs_edge;
      line_req    <= issue;
      if (vs_edge) begin
        // Frame geometry is captured only here so mid-frame changes wait a frame.
        h_lat      <= h_disp;
        v_lat      <= v_disp;
        line_cnt   <= '0;
        recv_cnt   <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        underflow  <= 1'b0;
        pixel_data <= '0;
      end else begin
        if (issue) begin
          line_num <= line_cnt;
          line_cnt <= line_cnt + 11'd1;
          recv_cnt <= '0;
        end else if (push) begin
          recv_cnt <= recv_cnt + 11'd1;
        end
        if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
        if (push && !pop)      count <= count + (FIFO_AW+1)'(1);
        else if (pop && !push) count <= count - (FIFO_AW+1)'(1);
        if (data_req && (state != IDLE)) begin
          if (!empty) begin
            pixel_data <= mem[rd_ptr];
          end else begin
            pixel_data <= UFLOW_COLOR;
            underflow  <= 1'b1;
          end
        end else begin
          pixel_data <= '0;
        end
      end
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

endmodule
`default_nettype wire
